alu_core: RTL and testbench



---
 rtl/alu_core.sv | 161 ++++++++++++++++
 tb/tb_alu_core.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//
// Parameterised W-bit arithmetic/logic unit for the execute stage. Every
// rising clock edge it samples an opcode, two operands and a carry-in, and
// one cycle later presents the registered result together with the carry,
// overflow, negative and zero flags. Latency 1, throughput 1 per cycle.
//
// Parameters
//   W         operand/result width (W >= 2)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over any operation)
//   opcode    4-bit operation select (all 16 codes defined)
//   a         operand A; data operand for shifts
//   b         operand B; unsigned shift amount for shifts
//   cin       carry-in, used only by ADC and SBC
//   y         registered result
//   cout      registered carry / last bit shifted out
//   overflow  registered signed-overflow flag (arithmetic opcodes only)
//   negative  registered y[W-1]
//   zero      registered (y == 0)
// ---------------------------------------------------------------------------
module alu_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] y,
    output logic         cout,
    output logic         overflow,
    output logic         negative,
    output logic         zero
);

    typedef enum logic [3:0] {
        OP_LSL   = 4'b0000,
        OP_LSR   = 4'b0001,
        OP_ASR   = 4'b0010,
        OP_NOT   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_ADD   = 4'b0111,
        OP_ADC   = 4'b1000,
        OP_SUB   = 4'b1001,
        OP_SBC   = 4'b1010,
        OP_NAND  = 4'b1011,
        OP_NOR   = 4'b1100,
        OP_XNOR  = 4'b1101,
        OP_PASSA = 4'b1110,
        OP_PASSB = 4'b1111
    } alu_op_e;

    alu_op_e op;
    assign op = alu_op_e'(opcode);

    // Shifts are done in a 2W-bit window so the bit shifted out last lands in
    // a fixed position next to the result. This covers b = 0, b = W and any
    // b > W without special cases: out-of-range shifts drain the window to
    // zero (or to sign for ASR), which is exactly the required result/cout.
    logic [2*W-1:0] lsl_win;
    logic [2*W-1:0] lsr_win;
    logic [2*W-1:0] asr_win;

    assign lsl_win = {{W{1'b0}}, a} << b;
    assign lsr_win = {a, {W{1'b0}}} >> b;
    assign asr_win = $signed({a, {W{1'b0}}}) >>> b;

    // Shared adder: subtraction feeds ~b and uses the carry-in as the +1
    // (SUB) or the incoming carry (SBC), so cout = 1 means "no borrow".
    logic         arith;
    logic         invert_b;
    logic         carry_in;
    logic [W-1:0] addend_b;
    logic [W:0]   sum;

    always_comb begin
        arith    = 1'b0;
        invert_b = 1'b0;
        carry_in = 1'b0;
        unique case (op)
            OP_ADD: begin arith = 1'b1; end
            OP_ADC: begin arith = 1'b1; carry_in = cin; end
            OP_SUB: begin arith = 1'b1; invert_b = 1'b1; carry_in = 1'b1; end
            OP_SBC: begin arith = 1'b1; invert_b = 1'b1; carry_in = cin; end
            default: ;
        endcase
    end

    assign addend_b = invert_b ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, addend_b} + {{W{1'b0}}, carry_in};

    logic [W-1:0] y_next;
    logic         cout_next;
    logic         ovf_next;

    // NOTE: every output of this block is assigned a default before the case
    // so that no path leaves a variable unassigned (which would infer a latch).
    always_comb begin
        y_next    = '0;
        cout_next = 1'b0;
        ovf_next  = 1'b0;
        unique case (op)
            OP_LSL: begin
                y_next    = lsl_win[W-1:0];
                cout_next = lsl_win[W];
            end
            OP_LSR: begin
                y_next    = lsr_win[2*W-1:W];
                cout_next = lsr_win[W-1];
            end
            OP_ASR: begin
                y_next    = asr_win[2*W-1:W];
                cout_next = asr_win[W-1];
            end
            OP_NOT:   y_next = ~a;
            OP_AND:   y_next = a & b;
            OP_OR:    y_next = a | b;
            OP_XOR:   y_next = a ^ b;
            OP_NAND:  y_next = ~(a & b);
            OP_NOR:   y_next = ~(a | b);
            OP_XNOR:  y_next = ~(a ^ b);
            OP_PASSA: y_next = a;
            OP_PASSB: y_next = b;
            default: begin
                y_next = sum[W-1:0];
            end
        endcase

        if (arith) begin
            cout_next = sum[W];
            // Same-sign addends producing a different-sign result.
            ovf_next  = (a[W-1] == addend_b[W-1]) && (sum[W-1] != a[W-1]);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b1;
        end else begin
            y        <= y_next;
            cout     <= cout_next;
            overflow <= ovf_next;
            negative <= y_next[W-1];
            zero     <= (y_next == '0);
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core
//
// Directed self-checking bench for alu_core at W = 4. Each vector is driven
// on the falling edge, clocked in on the next rising edge and compared 1 ns
// later against a hand-computed expectation packed as
// {y[3:0], cout, overflow, negative, zero}.
// ---------------------------------------------------------------------------
module tb_alu_core;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] y;
    logic         cout;
    logic         overflow;
    logic         negative;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    alu_core #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .y        (y),
        .cout     (cout),
        .overflow (overflow),
        .negative (negative),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] actual,
                         input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got y/c/v/n/z=%b_%b%b%b%b expected %b_%b%b%b%b",
                     tag, actual[7:4], actual[3], actual[2], actual[1], actual[0],
                     expected[7:4], expected[3], expected[2], expected[1],
                     expected[0]);
        end
    endtask

    // Drive one operation, clock it in, and compare the registered outputs.
    task automatic run(input string tag, input logic r, input logic [3:0] op,
                       input logic [3:0] va, input logic [3:0] vb,
                       input logic vc, input logic [7:0] expected);
        @(negedge clk);
        rst    = r;
        opcode = op;
        a      = va;
        b      = vb;
        cin    = vc;
        @(posedge clk);
        #1;
        check(tag, {y, cout, overflow, negative, zero}, expected);
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 4'b0111;
        a      = 4'b1111;
        b      = 4'b1111;
        cin    = 1'b1;

        // Reset with arbitrary inputs present.
        run("reset",      1'b1, 4'b0111, 4'b1111, 4'b1111, 1'b1, 8'b0000_0001);

        // Shifts                                                 y    c v n z
        run("lsl_1_1",    1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b0, 8'b0010_0000);
        run("lsr_1_1",    1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 8'b0000_1001);
        run("asr_1_1",    1'b0, 4'b0010, 4'b0001, 4'b0001, 1'b0, 8'b0000_1001);
        run("asr_9_1",    1'b0, 4'b0010, 4'b1001, 4'b0001, 1'b0, 8'b1100_1010);
        run("lsr_f_5",    1'b0, 4'b0001, 4'b1111, 4'b0101, 1'b0, 8'b0000_0001);
        run("lsl_b_w",    1'b0, 4'b0000, 4'b1011, 4'b0100, 1'b0, 8'b0000_1001);
        run("lsr_8_w",    1'b0, 4'b0001, 4'b1000, 4'b0100, 1'b0, 8'b0000_1001);
        run("asr_b_7",    1'b0, 4'b0010, 4'b1011, 4'b0111, 1'b0, 8'b1111_1010);
        run("lsl_6_0",    1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b1, 8'b0110_0000);
        run("lsl_e_3",    1'b0, 4'b0000, 4'b1110, 4'b0011, 1'b0, 8'b0000_1001);
        run("lsr_c_2",    1'b0, 4'b0001, 4'b1100, 4'b0010, 1'b0, 8'b0011_0000);

        // Logic and pass
        run("not_8",      1'b0, 4'b0011, 4'b1000, 4'b0000, 1'b1, 8'b0111_0000);
        run("and",        1'b0, 4'b0100, 4'b1111, 4'b0111, 1'b0, 8'b0111_0000);
        run("or",         1'b0, 4'b0101, 4'b1010, 4'b0101, 1'b0, 8'b1111_0010);
        run("xor",        1'b0, 4'b0110, 4'b1100, 4'b1010, 1'b0, 8'b0110_0000);
        run("nand",       1'b0, 4'b1011, 4'b1100, 4'b1010, 1'b0, 8'b0111_0000);
        run("nor",        1'b0, 4'b1100, 4'b1100, 4'b1010, 1'b0, 8'b0001_0000);
        run("xnor",       1'b0, 4'b1101, 4'b1100, 4'b1010, 1'b0, 8'b1001_0010);
        run("passa",      1'b0, 4'b1110, 4'b1010, 4'b0101, 1'b1, 8'b1010_0010);
        run("passb_zero", 1'b0, 4'b1111, 4'b1010, 4'b0000, 1'b0, 8'b0000_0001);

        // Add
        run("add_ovf",    1'b0, 4'b0111, 4'b0111, 4'b0001, 1'b0, 8'b1000_0110);
        run("add_cin_ig", 1'b0, 4'b0111, 4'b0010, 4'b0011, 1'b1, 8'b0101_0000);
        run("adc_wrap",   1'b0, 4'b1000, 4'b1111, 4'b0000, 1'b1, 8'b0000_1001);
        run("adc_cin0",   1'b0, 4'b1000, 4'b0100, 4'b0011, 1'b0, 8'b0111_0000);

        // Subtract
        run("sub_borrow", 1'b0, 4'b1001, 4'b0011, 4'b0101, 1'b0, 8'b1110_0010);
        run("sub_ovf",    1'b0, 4'b1001, 4'b1000, 4'b0001, 1'b0, 8'b0111_1100);
        run("sbc_cin0",   1'b0, 4'b1010, 4'b0101, 4'b0011, 1'b0, 8'b0001_1000);
        run("sbc_cin1",   1'b0, 4'b1010, 4'b0101, 4'b0101, 1'b1, 8'b0000_1001);

        // Back-to-back stream, then reset mid-stream, then recovery.
        run("pipe_0",     1'b0, 4'b0111, 4'b0001, 4'b0010, 1'b0, 8'b0011_0000);
        run("pipe_1",     1'b0, 4'b0000, 4'b0011, 4'b0001, 1'b0, 8'b0110_0000);
        run("pipe_2",     1'b0, 4'b1001, 4'b0000, 4'b0001, 1'b0, 8'b1111_0010);
        run("pipe_3",     1'b0, 4'b0110, 4'b1111, 4'b1111, 1'b0, 8'b0000_0001);
        run("pipe_rst",   1'b1, 4'b0111, 4'b0111, 4'b0001, 1'b0, 8'b0000_0001);
        run("pipe_after", 1'b0, 4'b1110, 4'b1001, 4'b0000, 1'b0, 8'b1001_0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
